instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Encoder/writer half of the instruction path: turns decoded instruction fields into
//  32-bit MIPS words using exactly the opcode/funct map the control decoder consumes.
//  Writes the words sequentially into instruction memory, so benches and boot logic can
//  load programs without hand-assembled hex.
//  Sits between a program source (bench or boot ROM sequencer) and the IMEM write port.
// PARAMETERS
//  DEPTH    64  words of IMEM available; the write address spans 0..DEPTH-1
//  AW       6   IMEM word-address width; clog2(DEPTH)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   1-cycle pulse: begin a new load at word address 0
//  finish     in   1   1-cycle pulse: end of program
//  in_valid   in   1   field bundle valid
//  in_ready   out  1   loader can accept a bundle
//  op_sel     in   5   operation code, table below
//  rs,rt,rd   in   5   register fields
//  imm        in   16  immediate / branch offset
//  target     in   26  jump target (J/JAL)
//  imem_we    out  1   IMEM write strobe
//  imem_addr  out  AW  IMEM word address
//  imem_wdata out  32  encoded instruction
//  count      out  AW+1  words written since start
//  busy       out  1   state is LOAD
//  done       out  1   state is DONE
//  full       out  1   state is FULL
//  err        out  1   sticky: illegal op_sel seen since start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; internal address=0.
//  op_sel -> encoding. R-type is {6'b0,rs,rt,rd,5'b0,funct}. Funct values:
//   ADD=0  (100000), SUB=1 (100010), AND=2 (100100), OR=3 (100101),
//   NOR=4  (100111), SLT=5 (101010), JR=6 (R-type, funct 001000, rt=rd=0).
//  I-type is {opc,rs,rt,imm}. Opcodes:
//   ADDI=7 001000, SUBI=8 011111, ANDI=9 001100, ORI=10 001101, SLTI=11 001010,
//   LW=12 100011, LB=13 100000, LH=14 100001, SW=15 101011, SB=16 101000,
//   SH=17 101001, LUI=18 001111 (rs forced 0), BEQ=19 000100, BEZ=20 000001,
//   BNE=21 000101.
//  J-type is {opc,target}: J=22 000010, JAL=23 000011. op_sel 24..31 is illegal.
//  FSM states: IDLE, LOAD, FULL, DONE.
//   IDLE: in_ready=0. On start -> LOAD; address and count cleared; err cleared.
//   LOAD: in_ready=1. A transfer occurs on a clk edge with in_valid&&in_ready.
//     Legal op: the next cycle has imem_we=1 for exactly 1 cycle, with
//     imem_addr = the current address and imem_wdata = the encoded word
//     (1-cycle registered latency). The address and count then increment.
//     Illegal op: the bundle is consumed, nothing is written, and err is set.
//     On finish -> DONE. If finish coincides with a transfer, the transfer
//     completes first (its write still occurs).
//     When count reaches DEPTH -> FULL after the final write.
//   FULL: in_ready=0 and no writes. A transfer attempt sets err. finish -> DONE.
//   DONE: in_ready=0. start -> LOAD with a fresh load.
//  start in LOAD or FULL restarts the load: address=0, count=0, err=0. Any pending
//   registered write for the last accepted bundle still issues.
//  imem_we is never asserted outside the cycle following an accepted legal transfer.
//  Async reset mid-load aborts immediately: imem_we drops in the same instant.
//   No partial word is written.
// TESTING
//  1. start; ADD rs=1 rt=2 rd=3 -> imem_we at addr 0, wdata 32'h00221820, count=1.
//  2. ADDI rs=0 rt=8 imm=16'h0005 -> wdata 32'h20080005. Then LW rs=29 rt=4 imm=8
//     -> wdata 32'h8FA40008 at addr 1.
//  3. BEQ rs=1 rt=2 imm=16'hFFFE -> 32'h1022FFFE. JAL target=26'h0000010
//     -> 32'h0C000010. JR rs=31 -> 32'h03E00008.
//  4. op_sel=25 -> no imem_we, err=1, count unchanged; the next legal op still
//     writes at the unchanged address.
//  5. DEPTH=4: 4 legal ops -> full=1, in_ready=0. A 5th in_valid causes no write
//     and sets err=1. finish -> done=1.
//  6. rst_n low mid-stream (in_valid held) -> all outputs 0 asynchronously.
//     After release: IDLE, in_ready=0 until start.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Encodes decoded MIPS instruction fields into 32-bit words and writes them
// sequentially into instruction memory starting at word address 0.
module instr_mem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          xfer;
  logic          last_word;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (op_sel)
      5'd0:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      5'd1:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      5'd2:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      5'd3:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      5'd4:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100111};
      5'd5:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      5'd6:  enc_word = {6'b000000, rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
      5'd7:  enc_word = {6'b001000, rs, rt, imm};
      5'd8:  enc_word = {6'b011111, rs, rt, imm};
      5'd9:  enc_word = {6'b001100, rs, rt, imm};
      5'd10: enc_word = {6'b001101, rs, rt, imm};
      5'd11: enc_word = {6'b001010, rs, rt, imm};
      5'd12: enc_word = {6'b100011, rs, rt, imm};
      5'd13: enc_word = {6'b100000, rs, rt, imm};
      5'd14: enc_word = {6'b100001, rs, rt, imm};
      5'd15: enc_word = {6'b101011, rs, rt, imm};
      5'd16: enc_word = {6'b101000, rs, rt, imm};
      5'd17: enc_word = {6'b101001, rs, rt, imm};
      5'd18: enc_word = {6'b001111, 5'b00000, rt, imm};
      5'd19: enc_word = {6'b000100, rs, rt, imm};
      5'd20: enc_word = {6'b000001, rs, rt, imm};
      5'd21: enc_word = {6'b000101, rs, rt, imm};
      5'd22: enc_word = {6'b000010, target};
      5'd23: enc_word = {6'b000011, target};
      default: enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = (state == LOAD);
  assign busy      = (state == LOAD);
  assign done      = (state == DONE);
  assign full      = (state == FULL);
  assign xfer      = in_valid && in_ready;
  assign last_word = (count == (AW+1)'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      // The write stage is independent of start so a bundle accepted just
      // before a restart still lands at its original address.
      imem_we <= 1'b0;
      if (xfer && enc_legal) begin
        imem_we    <= 1'b1;
        imem_addr  <= addr;
        imem_wdata <= enc_word;
      end

      if (start) begin
        state <= LOAD;
        addr  <= '0;
        count <= '0;
        err   <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (xfer) begin
              if (enc_legal) begin
                addr  <= addr + AW'(1);
                count <= count + (AW+1)'(1);
              end else begin
                err <= 1'b1;
              end
            end
            if (finish)
              state <= DONE;
            else if (xfer && enc_legal && last_word)
              state <= FULL;
          end
          FULL: begin
            if (in_valid) err <= 1'b1;
            if (finish) state <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader (DEPTH=4): table-driven encodings
// plus hand sequences for illegal ops, full, finish and async reset.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op_sel = '0, rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  count;
  logic        busy, done, full, err;

  instr_mem_loader #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .busy(busy), .done(done), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tg;
    logic [31:0] word;
  } vec_t;

  wr_t  sb[$];
  vec_t tbl[15];
  int   checks = 0;
  int   errors = 0;
  int   exp_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("waddr", 32'(imem_addr), e.addr);
        chk("wdata", imem_wdata, e.data);
      end
    end
  end

  task automatic set_fields(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
    op_sel = o; rs = s; rt = t; rd = d; imm = i; target = g;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic send(input vec_t v, input bit legal);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    set_fields(v.op, v.rs, v.rt, v.rd, v.imm, v.tg);
    in_valid = 1'b1;
    if (legal) begin
      sb.push_back('{32'(exp_addr), v.word});
      exp_addr++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221820};
    tbl[1]  = '{5'd7,  5'd0,  5'd8,  5'd0,  16'h0005, 26'h0,       32'h20080005};
    tbl[2]  = '{5'd12, 5'd29, 5'd4,  5'd0,  16'h0008, 26'h0,       32'h8FA40008};
    tbl[3]  = '{5'd19, 5'd1,  5'd2,  5'd0,  16'hFFFE, 26'h0,       32'h1022FFFE};
    tbl[4]  = '{5'd23, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010, 32'h0C000010};
    tbl[5]  = '{5'd6,  5'd31, 5'd5,  5'd6,  16'h0000, 26'h0,       32'h03E00008};
    tbl[6]  = '{5'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       32'h00853022};
    tbl[7]  = '{5'd18, 5'd7,  5'd9,  5'd0,  16'h1234, 26'h0,       32'h3C091234};
    tbl[8]  = '{5'd4,  5'd1,  5'd1,  5'd2,  16'h0000, 26'h0,       32'h00211027};
    tbl[9]  = '{5'd15, 5'd29, 5'd31, 5'd0,  16'h0010, 26'h0,       32'hAFBF0010};
    tbl[10] = '{5'd20, 5'd3,  5'd0,  5'd0,  16'h0004, 26'h0,       32'h04600004};
    tbl[11] = '{5'd22, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};
    tbl[12] = '{5'd8,  5'd2,  5'd3,  5'd0,  16'hFFFF, 26'h0,       32'h7C43FFFF};
    tbl[13] = '{5'd5,  5'd8,  5'd9,  5'd10, 16'h0000, 26'h0,       32'h0109502A};
    tbl[14] = '{5'd17, 5'd1,  5'd2,  5'd0,  16'h0002, 26'h0,       32'hA4220002};

    // Reset state
    #3;
    chk("reset_outputs", 32'({in_ready, imem_we, imem_addr, count, busy, done, full, err}), 32'd0);
    chk("reset_wdata", imem_wdata, 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Encoding table, restarting every three words to stay below DEPTH
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 0) pulse_start();
      send(tbl[i], 1'b1);
      chk("count", 32'(count), 32'((i % 3) + 1));
    end
    @(posedge clk); #1;

    // Illegal op: consumed, no write, err set, address unchanged
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);
    v = tbl[0]; v.op = 5'd25;
    send(v, 1'b0);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_count", 32'(count), 32'd0);
    send(tbl[0], 1'b1);
    chk("after_illegal_count", 32'(count), 32'd1);
    chk("err_sticky", 32'(err), 32'd1);

    // finish together with a transfer: write still happens, then DONE
    pulse_start();
    chk("restart_err", 32'(err), 32'd0);
    set_fields(tbl[1].op, tbl[1].rs, tbl[1].rt, tbl[1].rd, tbl[1].imm, tbl[1].tg);
    in_valid = 1'b1; finish = 1'b1;
    sb.push_back('{32'(exp_addr), tbl[1].word}); exp_addr++;
    @(posedge clk); #1;
    in_valid = 1'b0; finish = 1'b0;
    chk("finish_xfer_done", 32'(done), 32'd1);
    chk("finish_xfer_count", 32'(count), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);

    // Fill all four words, then an over-fill attempt and finish
    pulse_start();
    for (int i = 0; i < 4; i++) send(tbl[6 + i], 1'b1);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_err_before", 32'(err), 32'd0);
    set_fields(tbl[0].op, tbl[0].rs, tbl[0].rt, tbl[0].rd, tbl[0].imm, tbl[0].tg);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overfill_err", 32'(err), 32'd1);
    chk("overfill_count", 32'(count), 32'd4);
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    chk("full_finish_done", 32'(done), 32'd1);
    chk("full_finish_full", 32'(full), 32'd0);

    // Async reset mid-stream with in_valid held
    pulse_start();
    set_fields(tbl[0].op, tbl[0].rs, tbl[0].rt, tbl[0].rd, tbl[0].imm, tbl[0].tg);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{32'(exp_addr), tbl[0].word}); exp_addr++;
      @(posedge clk);
    end
    #1;
    chk("pre_reset_we", 32'(imem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({in_ready, imem_we, imem_addr, count, busy, done, full, err}), 32'd0);
    chk("async_reset_wdata", imem_wdata, 32'd0);
    sb.delete();
    #5 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd0);
    chk("post_reset_count", 32'(count), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
